// File: rtl/icache_pkg.sv
// Shared types and default geometry for the instruction cache.
//   addr_t / inst_t : 32-bit byte address and instruction word
//   state_e         : controller states
//   *_DEF, *_W      : default geometry and the address field widths it implies
package icache_pkg;

   typedef logic [31:0] addr_t;
   typedef logic [31:0] inst_t;

   typedef enum logic [1:0] {
      IDLE,
      LOOKUP,
      FILL_REQ,
      FILL_WAIT
   } state_e;

   localparam int unsigned NUM_LINES_DEF  = 64;
   localparam int unsigned LINE_WORDS_DEF = 4;

   // Byte address = {tag, index, offset, 2'b00}
   localparam int unsigned OFF_W = $clog2(LINE_WORDS_DEF);
   localparam int unsigned IDX_W = $clog2(NUM_LINES_DEF);
   localparam int unsigned TAG_W = 32 - 2 - OFF_W - IDX_W;

endpackage

// File: rtl/inst_cache_if.sv
// Fetch-side and memory-side handshake bundle of the instruction cache.
//   slave  : the cache (accepts fetch requests, issues memory reads)
//   master : the environment (fetch queue + memory)
// Signals:
//   ireq_valid/ireq_ready/ireq_addr : fetch request
//   iresp_valid/iresp_rdata         : one-cycle instruction response
//   kill / flush                    : branch redirect / fence.i
//   memreq_valid/ready/addr         : word read request to memory
//   memresp_valid/rdata             : memory read data
interface inst_cache_if;
   import icache_pkg::*;

   logic  ireq_valid;
   logic  ireq_ready;
   addr_t ireq_addr;
   logic  iresp_valid;
   inst_t iresp_rdata;
   logic  kill;
   logic  flush;
   logic  memreq_valid;
   logic  memreq_ready;
   addr_t memreq_addr;
   logic  memresp_valid;
   inst_t memresp_rdata;

   modport slave (
      input  ireq_valid, ireq_addr, kill, flush,
             memreq_ready, memresp_valid, memresp_rdata,
      output ireq_ready, iresp_valid, iresp_rdata,
             memreq_valid, memreq_addr
   );

   modport master (
      output ireq_valid, ireq_addr, kill, flush,
             memreq_ready, memresp_valid, memresp_rdata,
      input  ireq_ready, iresp_valid, iresp_rdata,
             memreq_valid, memreq_addr
   );

endinterface

// File: rtl/icache_data_array.sv
// Instruction storage: 2**ADDR_W words of 32 bits.
//   clk_i   : write clock
//   we_i    : write enable
//   waddr_i : write address {index, offset}
//   wdata_i : write data
//   raddr_i : read address {index, offset}, combinational read
//   rdata_o : read data
module icache_data_array
   import icache_pkg::*;
#(
   parameter int unsigned ADDR_W = 8
) (
   input  logic              clk_i,
   input  logic              we_i,
   input  logic [ADDR_W-1:0] waddr_i,
   input  inst_t             wdata_i,
   input  logic [ADDR_W-1:0] raddr_i,
   output inst_t             rdata_o
);

   localparam int unsigned DEPTH = 1 << ADDR_W;

   inst_t mem_q [DEPTH];

   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/inst_cache.sv
// Direct-mapped read-only instruction cache with word-by-word line refill.
//   clk   : rising-edge clock
//   reset : asynchronous, active-high
//   bus   : fetch request/response, kill, flush and memory read port
module inst_cache
   import icache_pkg::*;
#(
   parameter int unsigned NUM_LINES  = NUM_LINES_DEF,
   parameter int unsigned LINE_WORDS = LINE_WORDS_DEF
) (
   input  logic         clk,
   input  logic         reset,
   inst_cache_if.slave  bus
);

   localparam int unsigned OW = $clog2(LINE_WORDS);
   localparam int unsigned IW = $clog2(NUM_LINES);
   localparam int unsigned TW = 30 - OW - IW;
   localparam logic [OW-1:0] LAST_WORD = OW'(LINE_WORDS - 1);

   state_e               state_q;
   logic [29:0]          waddr_q;          // latched word address of the request in flight
   logic [OW-1:0]        cnt_q;            // next word of the line to fetch
   logic                 kill_pending_q;
   logic                 flush_pending_q;
   logic                 fill_done_q;      // this LOOKUP follows a completed fill
   logic [NUM_LINES-1:0] valid_q;
   logic [TW-1:0]        tag_q [NUM_LINES];

   logic [OW-1:0] off;
   logic [IW-1:0] idx;
   logic [TW-1:0] tag;
   logic          hit;
   logic          accept;
   logic          fill_we;
   logic          fill_last;
   inst_t         rdata;
   logic          unused_addr_lsbs;

   assign off = waddr_q[0 +: OW];
   assign idx = waddr_q[OW +: IW];
   assign tag = waddr_q[29 -: TW];

   assign unused_addr_lsbs = ^bus.ireq_addr[1:0];

   // A LOOKUP right after a fill always hits: a flush applied at fill
   // completion clears the valid bit, but the words are still in the array.
   always_comb begin
      hit = 1'b0;
      if (state_q == LOOKUP) begin
         hit = fill_done_q || (valid_q[idx] && (tag_q[idx] == tag));
      end
   end

   assign bus.ireq_ready  = !reset &&
                            ((state_q == IDLE) || (hit && !kill_pending_q));
   assign accept          = bus.ireq_valid && bus.ireq_ready;
   assign bus.iresp_valid = hit && !bus.kill && !kill_pending_q;
   assign bus.iresp_rdata = bus.iresp_valid ? rdata : '0;

   assign bus.memreq_valid = (state_q == FILL_REQ);
   assign bus.memreq_addr  = (state_q == FILL_REQ) ?
                             {waddr_q[29:OW], cnt_q, 2'b00} : '0;

   assign fill_we   = (state_q == FILL_WAIT) && bus.memresp_valid;
   assign fill_last = fill_we && (cnt_q == LAST_WORD);

   icache_data_array #(
      .ADDR_W (IW + OW)
   ) u_data (
      .clk_i   (clk),
      .we_i    (fill_we),
      .waddr_i ({idx, cnt_q}),
      .wdata_i (bus.memresp_rdata),
      .raddr_i ({idx, off}),
      .rdata_o (rdata)
   );

   always_ff @(posedge clk) begin
      if (fill_last) begin
         tag_q[idx] <= tag;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q         <= IDLE;
         waddr_q         <= '0;
         cnt_q           <= '0;
         kill_pending_q  <= 1'b0;
         flush_pending_q <= 1'b0;
         fill_done_q     <= 1'b0;
         valid_q         <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (accept) begin
                  waddr_q <= bus.ireq_addr[31:2];
                  state_q <= LOOKUP;
               end
            end

            LOOKUP: begin
               fill_done_q <= 1'b0;
               if (hit) begin
                  kill_pending_q <= 1'b0;
                  if (accept) begin
                     waddr_q <= bus.ireq_addr[31:2];
                  end else begin
                     state_q <= IDLE;
                  end
               end else begin
                  // The line is about to be overwritten; a kill seen here
                  // targets the request now going to memory.
                  valid_q[idx]   <= 1'b0;
                  cnt_q          <= '0;
                  kill_pending_q <= bus.kill;
                  state_q        <= FILL_REQ;
               end
            end

            FILL_REQ: begin
               if (bus.kill)  kill_pending_q  <= 1'b1;
               if (bus.flush) flush_pending_q <= 1'b1;
               if (bus.memreq_ready) begin
                  state_q <= FILL_WAIT;
               end
            end

            FILL_WAIT: begin
               if (bus.kill)  kill_pending_q  <= 1'b1;
               if (bus.flush) flush_pending_q <= 1'b1;
               if (bus.memresp_valid) begin
                  cnt_q <= cnt_q + 1'b1;
                  if (cnt_q == LAST_WORD) begin
                     state_q         <= LOOKUP;
                     fill_done_q     <= 1'b1;
                     flush_pending_q <= 1'b0;
                     if (bus.flush || flush_pending_q) begin
                        valid_q <= '0;
                     end else begin
                        valid_q[idx] <= 1'b1;
                     end
                  end else begin
                     state_q <= FILL_REQ;
                  end
               end
            end

            default: state_q <= IDLE;
         endcase

         if (bus.flush && ((state_q == IDLE) || (state_q == LOOKUP))) begin
            valid_q <= '0;
         end
      end
   end

endmodule
